instruction_fetcher: RTL and testbench

- Front-end initiator on the instruction-cache read interface.
- Holds the PC (instruction-word address) and presents it to the cache every cycle.
- Captures the instruction returned when the cache signals a hit, and pushes {pc, inst} into a small in-order queue drained by the decoder.
- Handles back-end redirects (branch/jalr resolution) and statically follows JAL in the front end.

---
 rtl/instruction_fetcher_pkg.sv | 22 ++
 rtl/instruction_fetcher_queue.sv | 69 ++++++
 rtl/instruction_fetcher.sv | 90 +++++++++
 tb/tb_instruction_fetcher.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetcher_pkg.sv
// Shared front-end definitions: RV32 opcode constants, default widths and
// the J-type immediate decoders used by both the fetcher and the decoder.
package instruction_fetcher_pkg;

    localparam int DEF_INST_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 17;

    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    // Full J-type byte offset, bit 0 always zero.
    function automatic logic [20:0] j_imm(input logic [31:0] inst);
        return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // J-type offset expressed in instruction words (byte offset bits [20:2]).
    function automatic logic [18:0] j_word_offset(input logic [31:0] inst);
        return {inst[31], inst[19:12], inst[20], inst[30:22]};
    endfunction

endpackage

// File: rtl/instruction_fetcher_queue.sv
// In-order instruction queue: synchronous FIFO with flush and a
// combinational head output. A push is refused while full even if a pop
// happens in the same cycle, so full stays a pure register decode.
module instruction_fetcher_queue #(
    parameter int DEPTH_LOG = 2,
    parameter int WIDTH     = 49
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int DEPTH = 1 << DEPTH_LOG;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG:0]   count_q, count_d;
    logic                 do_push;
    logic                 do_pop;

    assign full_o  = (count_q == (DEPTH_LOG+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    // Next-state for pointers and occupancy; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (DEPTH_LOG+1)'(1);
                2'b01:   count_d = count_q - (DEPTH_LOG+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage and pointer registers; storage cleared on reset so the head reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/instruction_fetcher.sv
// Instruction fetcher: owns the PC, presents it to the instruction cache
// every cycle, queues {pc, inst} on each hit, follows JAL statically and
// restarts from the back-end redirect address on a flush.
//
// Decoder handshake: out_valid is high whenever the queue holds an entry and
// out_pc/out_inst describe that head entry; the head is consumed on a cycle
// where rdy, out_valid and out_ready are all high and no redirect is present.
// out_valid never depends on out_ready.
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter int                    INST_WIDTH      = DEF_INST_WIDTH,
    parameter int                    ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int                    QUEUE_DEPTH_LOG = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    output logic [ADDR_WIDTH-1:0] inst_cache_read_addr,
    input  logic                  inst_cache_read_done,
    input  logic [INST_WIDTH-1:0] inst_cache_read_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [ADDR_WIDTH-1:0] out_pc
);
    localparam int ENTRY_WIDTH = ADDR_WIDTH + INST_WIDTH;

    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic                   q_full;
    logic                   q_empty;
    logic [ENTRY_WIDTH-1:0] q_head;
    logic                   accept;
    logic                   dequeue;
    logic                   flush;
    logic                   is_jal;
    logic [ADDR_WIDTH-1:0]  jal_target;
    logic [ADDR_WIDTH-1:0]  seq_target;

    // The cache sees the PC directly; it is held stable across a miss.
    assign inst_cache_read_addr = pc_q;

    assign flush   = rdy & redirect_valid;
    assign accept  = rdy & inst_cache_read_done & ~q_full & ~redirect_valid;
    assign dequeue = rdy & out_valid & out_ready & ~redirect_valid;

    // JAL target: word offset sign-extended (or truncated) to the PC width.
    assign is_jal     = (inst_cache_read_data[6:0] == OPCODE_JAL);
    assign jal_target = pc_q + ADDR_WIDTH'(signed'(j_word_offset(inst_cache_read_data[31:0])));
    assign seq_target = pc_q + ADDR_WIDTH'(1);

    // Next PC: redirect beats fetch; branches other than JAL fall through.
    always_comb begin
        pc_d = pc_q;
        if (flush) begin
            pc_d = redirect_addr;
        end else if (accept) begin
            pc_d = is_jal ? jal_target : seq_target;
        end
    end

    // PC register; reset overrides rdy and any pending redirect.
    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    instruction_fetcher_queue #(
        .DEPTH_LOG (QUEUE_DEPTH_LOG),
        .WIDTH     (ENTRY_WIDTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .push_i      (accept),
        .push_data_i ({pc_q, inst_cache_read_data}),
        .pop_i       (dequeue),
        .head_o      (q_head),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

    assign out_valid = ~q_empty;
    assign out_pc    = q_head[ENTRY_WIDTH-1:INST_WIDTH];
    assign out_inst  = q_head[INST_WIDTH-1:0];

endmodule

// File: tb/tb_instruction_fetcher.sv
// Bench for instruction_fetcher: directed scenarios plus a random run, with a
// behavioural reference of PC and queue contents acting as the scoreboard.
module tb_instruction_fetcher;
    localparam int AW = 17;
    localparam int IW = 32;
    localparam int EW = AW + IW;
    localparam logic [IW-1:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy;
    logic [AW-1:0] inst_cache_read_addr;
    logic          inst_cache_read_done;
    logic [IW-1:0] inst_cache_read_data;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_inst;
    logic [AW-1:0] out_pc;

    logic [EW-1:0] exp_q[$];
    logic [AW-1:0] m_pc;
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    instruction_fetcher dut (
        .clk                  (clk),
        .rst                  (rst),
        .rdy                  (rdy),
        .inst_cache_read_addr (inst_cache_read_addr),
        .inst_cache_read_done (inst_cache_read_done),
        .inst_cache_read_data (inst_cache_read_data),
        .redirect_valid       (redirect_valid),
        .redirect_addr        (redirect_addr),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_inst             (out_inst),
        .out_pc               (out_pc)
    );

    // Reference next PC: JAL byte offset -> word offset, else +1, mod 2^AW.
    function automatic logic [AW-1:0] model_next_pc(input logic [AW-1:0] pc, input logic [IW-1:0] d);
        logic [20:0] imm;
        logic [31:0] ext;
        if (d[6:0] == 7'h6F) begin
            imm = {d[31], d[19:12], d[20], d[30:21], 1'b0};
            ext = {{11{imm[20]}}, imm};
            ext = $signed(ext) >>> 2;
            return pc + ext[AW-1:0];
        end
        return pc + AW'(1);
    endfunction

    // One clock: check address/valid, advance the reference (scoreboard
    // pops are compared against the DUT head), then cross the edge.
    task automatic step();
        logic [EW-1:0] head;
        int sz;
        #2;
        n_tests++;
        if (inst_cache_read_addr !== m_pc) begin
            n_fail++;
            $display("FAIL sb_addr: got %h expected %h at %0t", inst_cache_read_addr, m_pc, $time);
        end
        n_tests++;
        if (out_valid !== (exp_q.size() != 0)) begin
            n_fail++;
            $display("FAIL sb_valid: got %b expected %b at %0t", out_valid, exp_q.size() != 0, $time);
        end
        if (rst) begin
            m_pc = '0;
            exp_q.delete();
        end else if (rdy) begin
            if (redirect_valid) begin
                exp_q.delete();
                m_pc = redirect_addr;
            end else begin
                sz = exp_q.size();
                if (sz != 0 && out_ready) begin
                    head = exp_q.pop_front();
                    n_tests++;
                    if ({out_pc, out_inst} !== head) begin
                        n_fail++;
                        $display("FAIL sb_head: got pc=%h inst=%h expected pc=%h inst=%h at %0t",
                                 out_pc, out_inst, head[EW-1:IW], head[IW-1:0], $time);
                    end
                end
                if (inst_cache_read_done && sz < 4) begin
                    exp_q.push_back({m_pc, inst_cache_read_data});
                    m_pc = model_next_pc(m_pc, inst_cache_read_data);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; rdy = 1'b1; redirect_valid = 1'b0; redirect_addr = '0;
        inst_cache_read_done = 1'b0; inst_cache_read_data = NOP; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b0; redirect_valid = 1'b1; redirect_addr = 17'h1234;
        inst_cache_read_done = 1'b1; out_ready = 1'b1;
        step();
        n_tests++; if (inst_cache_read_addr !== 17'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", inst_cache_read_addr); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_tests++; if (out_pc !== 17'h0) begin n_fail++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
        n_tests++; if (out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_out_inst: got %h expected 0", out_inst); end
        idle_inputs();
    endtask

    task automatic test_sequential_fetch();
        inst_cache_read_done = 1'b1; inst_cache_read_data = NOP; out_ready = 1'b1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL seq_valid_before: got %b expected 0", out_valid); end
        step();
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid_after: got %b expected 1", out_valid); end
        n_tests++; if (out_pc !== 17'h0) begin n_fail++; $display("FAIL seq_first_pc: got %h expected 0", out_pc); end
        repeat (6) step();
        n_tests++; if (inst_cache_read_addr !== 17'h7) begin n_fail++; $display("FAIL seq_addr: got %h expected 7", inst_cache_read_addr); end
        n_tests++; if (out_pc !== 17'h6) begin n_fail++; $display("FAIL seq_out_pc: got %h expected 6", out_pc); end
        inst_cache_read_done = 1'b0;
        step();
        idle_inputs();
    endtask

    task automatic test_miss();
        redirect_valid = 1'b1; redirect_addr = 17'h10; out_ready = 1'b1;
        step();
        redirect_valid = 1'b0; out_ready = 1'b0; inst_cache_read_done = 1'b0;
        repeat (5) begin
            n_tests++; if (inst_cache_read_addr !== 17'h10) begin n_fail++; $display("FAIL miss_addr: got %h expected 10", inst_cache_read_addr); end
            step();
        end
        inst_cache_read_done = 1'b1; inst_cache_read_data = NOP;
        step();
        inst_cache_read_done = 1'b0;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL miss_valid: got %b expected 1", out_valid); end
        n_tests++; if (out_pc !== 17'h10) begin n_fail++; $display("FAIL miss_pc: got %h expected 10", out_pc); end
        out_ready = 1'b1;
        step();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL miss_single: got %b expected 0", out_valid); end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        rst = 1'b1;
        step();
        rst = 1'b0; inst_cache_read_done = 1'b1; inst_cache_read_data = NOP; out_ready = 1'b0;
        repeat (6) step();
        n_tests++; if (inst_cache_read_addr !== 17'h4) begin n_fail++; $display("FAIL bp_full_addr: got %h expected 4", inst_cache_read_addr); end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
        n_tests++; if (out_pc !== 17'h0) begin n_fail++; $display("FAIL bp_head: got %h expected 0", out_pc); end
        out_ready = 1'b1;
        step();
        n_tests++; if (inst_cache_read_addr !== 17'h4) begin n_fail++; $display("FAIL bp_full_deq_addr: got %h expected 4", inst_cache_read_addr); end
        for (int i = 1; i < 4; i++) begin
            n_tests++; if (out_pc !== AW'(i)) begin n_fail++; $display("FAIL bp_order: got %h expected %h", out_pc, AW'(i)); end
            step();
        end
        n_tests++; if (out_pc !== 17'h4) begin n_fail++; $display("FAIL bp_resume: got %h expected 4", out_pc); end
        inst_cache_read_done = 1'b0;
        repeat (4) step();
        idle_inputs();
    endtask

    task automatic test_jal();
        redirect_valid = 1'b1; redirect_addr = 17'h20;
        step();
        redirect_valid = 1'b0; inst_cache_read_done = 1'b1; inst_cache_read_data = 32'h0100_006F;
        step();
        n_tests++; if (inst_cache_read_addr !== 17'h24) begin n_fail++; $display("FAIL jal_fwd: got %h expected 24", inst_cache_read_addr); end
        inst_cache_read_data = 32'hFF9F_F06F;
        step();
        n_tests++; if (inst_cache_read_addr !== 17'h22) begin n_fail++; $display("FAIL jal_back: got %h expected 22", inst_cache_read_addr); end
        n_tests++; if (out_pc !== 17'h20 || out_inst !== 32'h0100_006F) begin
            n_fail++; $display("FAIL jal_head: got pc=%h inst=%h expected pc=20 inst=0100006f", out_pc, out_inst);
        end
        inst_cache_read_done = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        idle_inputs();
    endtask

    task automatic test_redirect_flush();
        redirect_valid = 1'b1; redirect_addr = 17'h40;
        step();
        redirect_valid = 1'b0; inst_cache_read_done = 1'b1; inst_cache_read_data = NOP;
        repeat (3) step();
        redirect_valid = 1'b1; redirect_addr = 17'h1FFFF; out_ready = 1'b1;
        step();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %b expected 0", out_valid); end
        n_tests++; if (inst_cache_read_addr !== 17'h1FFFF) begin n_fail++; $display("FAIL redir_addr: got %h expected 1ffff", inst_cache_read_addr); end
        redirect_valid = 1'b0; out_ready = 1'b0;
        step();
        n_tests++; if (inst_cache_read_addr !== 17'h0) begin n_fail++; $display("FAIL redir_wrap: got %h expected 0", inst_cache_read_addr); end
        n_tests++; if (out_pc !== 17'h1FFFF) begin n_fail++; $display("FAIL redir_head: got %h expected 1ffff", out_pc); end
        inst_cache_read_done = 1'b0; out_ready = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_rdy_freeze();
        inst_cache_read_done = 1'b1; inst_cache_read_data = NOP;
        step();
        rdy = 1'b0; redirect_valid = 1'b1; redirect_addr = 17'h55; out_ready = 1'b1;
        repeat (3) begin
            step();
            n_tests++; if (inst_cache_read_addr !== 17'h1) begin n_fail++; $display("FAIL frz_addr: got %h expected 1", inst_cache_read_addr); end
            n_tests++; if (out_valid !== 1'b1 || out_pc !== 17'h0) begin
                n_fail++; $display("FAIL frz_queue: got valid=%b pc=%h expected valid=1 pc=0", out_valid, out_pc);
            end
        end
        rdy = 1'b1;
        step();
        n_tests++; if (inst_cache_read_addr !== 17'h55) begin n_fail++; $display("FAIL frz_redir: got %h expected 55", inst_cache_read_addr); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL frz_flush: got %b expected 0", out_valid); end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [IW-1:0] d;
        repeat (400) begin
            rst                  = ($urandom_range(0, 99) == 0);
            rdy                  = ($urandom_range(0, 9) != 0);
            inst_cache_read_done = ($urandom_range(0, 3) != 0);
            out_ready            = ($urandom_range(0, 2) != 0);
            redirect_valid       = ($urandom_range(0, 24) == 0);
            redirect_addr        = AW'($urandom_range(0, 17'h1FFFF));
            d = $urandom();
            if ($urandom_range(0, 4) == 0) d[6:0] = 7'h6F;
            else if (d[6:0] == 7'h6F)      d[0] = 1'b0;
            inst_cache_read_data = d;
            step();
        end
        idle_inputs();
        out_ready = 1'b1;
        repeat (5) step();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_drain: got %b expected 0", out_valid); end
    endtask

    initial begin
        idle_inputs();
        rst  = 1'b1;
        m_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_sequential_fetch();
        test_miss();
        test_backpressure();
        test_jal();
        test_redirect_flush();
        test_rdy_freeze();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
